// File: rtl/booth_radix4_mul.sv
// Multi-cycle radix-4 (modified) Booth multiplier with valid/ready handshakes.
// Retires two multiplier bits per cycle; per-transaction signed/unsigned mode.
module booth_radix4_mul #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned XW = WIDTH + 2;
    localparam int unsigned N  = XW / 2;
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned PW = 2 * WIDTH;

    // Reject odd or too-narrow operand widths at elaboration.
    if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_width_check
        $error("booth_radix4_mul: WIDTH must be even and >= 4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state, w_state_nx;
    logic [XW-1:0]   r_a, w_a_nx;
    logic [XW-1:0]   r_acc, w_acc_nx;
    logic [XW-1:0]   r_m, w_m_nx;
    logic            r_q, w_q_nx;
    logic [CW-1:0]   r_cnt, w_cnt_nx;
    logic [PW-1:0]   r_product, w_product_nx;
    logic            r_out_valid, w_out_valid_nx;
    logic            r_in_ready, w_in_ready_nx;
    logic            r_busy, w_busy_nx;

    logic [XW-1:0]   w_a_ext;
    logic [XW-1:0]   w_b_ext;
    logic [XW:0]     w_a_x;
    logic [XW:0]     w_a2;
    logic [XW:0]     w_addend;
    logic [XW:0]     w_sum;

    // Operand widening: the two extra bits make unsigned operands look positive.
    always_comb begin
        w_a_ext = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
        w_b_ext = signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
    end

    // Booth triplet decode and the XW+1 bit partial-product adder.
    always_comb begin
        w_a_x    = {r_a[XW-1], r_a};
        w_a2     = {r_a, 1'b0};
        w_addend = '0;
        unique case ({r_m[1:0], r_q})
            3'b001, 3'b010: w_addend = w_a_x;
            3'b011:         w_addend = w_a2;
            3'b100:         w_addend = '0 - w_a2;
            3'b101, 3'b110: w_addend = '0 - w_a_x;
            default:        w_addend = '0;
        endcase
        w_sum = {r_acc[XW-1], r_acc} + w_addend;
    end

    // Next-state and next-register logic.
    always_comb begin
        w_state_nx     = r_state;
        w_a_nx         = r_a;
        w_acc_nx       = r_acc;
        w_m_nx         = r_m;
        w_q_nx         = r_q;
        w_cnt_nx       = r_cnt;
        w_product_nx   = r_product;
        w_out_valid_nx = r_out_valid;
        w_in_ready_nx  = r_in_ready;
        w_busy_nx      = r_busy;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_a_nx        = w_a_ext;
                    w_m_nx        = w_b_ext;
                    w_acc_nx      = '0;
                    w_q_nx        = 1'b0;
                    w_cnt_nx      = CW'(N);
                    w_in_ready_nx = 1'b0;
                    w_busy_nx     = 1'b1;
                    w_state_nx    = S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == '0) begin
                    w_product_nx   = PW'({r_acc, r_m});
                    w_out_valid_nx = 1'b1;
                    w_state_nx     = S_DONE;
                end else begin
                    // Arithmetic shift of {sum, M, Q(-1)} right by two.
                    w_acc_nx = {w_sum[XW], w_sum[XW:2]};
                    w_m_nx   = {w_sum[1:0], r_m[XW-1:2]};
                    w_q_nx   = r_m[1];
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end
            S_DONE: begin
                if (r_out_valid && out_ready) begin
                    w_out_valid_nx = 1'b0;
                    w_in_ready_nx  = 1'b1;
                    w_busy_nx      = 1'b0;
                    w_state_nx     = S_IDLE;
                end
            end
            default: begin
                w_state_nx     = S_IDLE;
                w_out_valid_nx = 1'b0;
                w_in_ready_nx  = 1'b1;
                w_busy_nx      = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_acc       <= '0;
            r_m         <= '0;
            r_q         <= 1'b0;
            r_cnt       <= '0;
            r_product   <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_a         <= w_a_nx;
            r_acc       <= w_acc_nx;
            r_m         <= w_m_nx;
            r_q         <= w_q_nx;
            r_cnt       <= w_cnt_nx;
            r_product   <= w_product_nx;
            r_out_valid <= w_out_valid_nx;
            r_in_ready  <= w_in_ready_nx;
            r_busy      <= w_busy_nx;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign product   = r_product;
    assign busy      = r_busy;

endmodule

// File: tb/tb_booth_radix4_mul.sv
// Scoreboard bench for booth_radix4_mul (WIDTH=8): directed corner cases,
// backpressure, mid-operation reset and a randomized sweep vs. a reference model.
module tb_booth_radix4_mul;

    localparam int unsigned W = 8;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           signed_mode;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic           busy;

    int total = 0;
    int bad   = 0;
    logic [2*W-1:0] exp_q[$];
    logic rand_bp = 1'b0;

    booth_radix4_mul #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .product     (product),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer multiply of the operands as interpreted by mode.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic m);
        longint sx;
        longint sy;
        sx = m ? longint'($signed(x)) : longint'(x);
        sy = m ? longint'($signed(y)) : longint'(y);
        return (2*W)'(sx * sy);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: a handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got %h want none at %0t", product, $time);
            end else begin
                chk("product", 32'(product), 32'(exp_q.pop_front()));
            end
        end
    end

    // Random consumer backpressure during the sweep.
    always @(posedge clk) begin
        #1;
        if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    end

    // Issue one operation; returns just after the accepting edge.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic m,
                         input bit push);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout: got 0 want 1 at %0t", $time);
        end
        in_valid = 1'b1; a = x; b = y; signed_mode = m;
        @(posedge clk);
        if (push) exp_q.push_back(ref_mul(x, y, m));
        #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*W-1:0] held;
        int cyc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; signed_mode = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency: out_valid rises after the 6th edge following accept.
        do_op(8'hFD, 8'h07, 1'b1, 1'b1);
        chk("busy_calc", 32'(busy), 32'd1);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!out_valid && cyc < 20);
        chk("latency", 32'(cyc), 32'd6);
        chk("lat_product", 32'(product), 32'h0000FFEB);
        drain();

        do_op(8'h80, 8'h80, 1'b1, 1'b1);
        do_op(8'hFF, 8'hFF, 1'b0, 1'b1);
        do_op(8'hFF, 8'h02, 1'b1, 1'b1);
        do_op(8'hFF, 8'h02, 1'b0, 1'b1);
        do_op(8'h7F, 8'h80, 1'b1, 1'b1);
        do_op(8'h00, 8'hA5, 1'b1, 1'b1);
        do_op(8'h80, 8'h7F, 1'b0, 1'b1);
        drain();

        // Backpressure: result holds, new operands are ignored.
        out_ready = 1'b0;
        do_op(8'hFF, 8'h02, 1'b1, 1'b1);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        held = product;
        chk("bp_first", 32'(held), 32'h0000FFFE);
        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 0) begin
                in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_product", 32'(product), 32'(held));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_hs_valid", 32'(out_valid), 32'd0);
        chk("post_hs_in_ready", 32'(in_ready), 32'd1);
        chk("post_hs_product", 32'(product), 32'(held));
        drain();

        // Reset during the third CALC cycle discards the operation.
        do_op(8'h11, 8'h22, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_product", 32'(product), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(8'h05, 8'hFA, 1'b1, 1'b1);
        drain();

        // Randomized sweep with random gaps and consumer stalls.
        rand_bp = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            x = W'($urandom);
            y = W'($urandom);
            if (i % 17 == 0) x = 8'h80;
            if (i % 23 == 0) y = 8'hFF;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            do_op(x, y, 1'($urandom), 1'b1);
        end
        rand_bp = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
